// File: rtl/hqc_pkg.sv
// Shared HQC constants, derived result-stream geometry helpers and the
// result streamer state encoding.
package hqc_pkg;

  localparam int RAMWIDTH_DEF = 32;
  localparam int N_HQC128     = 17669;
  localparam int N_HQC192     = 35851;
  localparam int N_HQC256     = 57637;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } stream_state_e;

  // Number of RAM words holding an n-bit polynomial, padded up to a whole word.
  function automatic int calc_words(input int n, input int w);
    return (n + (w - n % w) % w) / w;
  endfunction

  // Valid bits in the final word; a full word when n is a multiple of w.
  function automatic int calc_last_bits(input int n, input int w);
    return n - (calc_words(n, w) - 1) * w;
  endfunction

  // Byte swap as a lane map: output byte lane takes input byte (nbytes-1-lane).
  function automatic int byte_swap(input int lane, input int nbytes);
    return nbytes - 1 - lane;
  endfunction

endpackage

// File: rtl/poly_result_streamer_chk.sv
// Occupancy checker for the result streamer read pipeline and output FIFO.
module poly_result_streamer_chk #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input logic             clk,
  input logic             rst,
  input logic             i_push,
  input logic             i_pop,
  input logic [CNT_W-1:0] i_count,
  input logic [CNT_W-1:0] i_inflight
);

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_pop && (int'(i_count) == DEPTH)))
    else $error("stream fifo overflow: push into full fifo without pop");

  a_occupancy_bound: assert property (@(posedge clk) disable iff (rst)
    (int'(i_inflight) + int'(i_count)) <= DEPTH)
    else $error("in-flight reads plus stored words exceed fifo depth");

endmodule

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with registered storage; the head entry is
// presented combinationally from the storage array.
module stream_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_do_pop  = i_rd_en && (r_count != {CNT_W{1'b0}});
  assign w_do_push = i_wr_en && ((r_count != CNT_FULL) || w_do_pop);

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_empty   = (r_count == {CNT_W{1'b0}});
  assign o_count   = r_count;

  // Storage array; cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? {PTR_W{1'b0}} : r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? {PTR_W{1'b0}} : r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/poly_result_streamer.sv
// Reads the poly_mult result memory after each completion edge and streams
// the byte-swapped, padding-masked product as a valid/ready word stream.
module poly_result_streamer
  import hqc_pkg::*;
#(
  parameter int N          = N_HQC128,
  parameter int RAMWIDTH   = RAMWIDTH_DEF,
  parameter int ADDR_WIDTH = 11,
  parameter int RD_LAT     = 1,
  parameter int WORDS      = calc_words(N, RAMWIDTH),
  parameter int LAST_BITS  = calc_last_bits(N, RAMWIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pm_valid,
  output logic [ADDR_WIDTH-1:0] addr_result,
  output logic                  rd_dout,
  input  logic [RAMWIDTH-1:0]   dout,
  output logic [RAMWIDTH-1:0]   m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int FIFO_DEPTH = RD_LAT + 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W      = CNT_W + 2;
  localparam int NBYTES     = RAMWIDTH / 8;
  localparam logic [RAMWIDTH-1:0]   LAST_MASK = {RAMWIDTH{1'b1}} >> (RAMWIDTH - LAST_BITS);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(WORDS - 1);

  stream_state_e         r_state;
  stream_state_e         w_state_nxt;
  logic                  r_pv_q;
  logic [ADDR_WIDTH-1:0] r_rd_idx;
  logic [ADDR_WIDTH-1:0] r_out_idx;
  logic [RD_LAT-1:0]     r_tag_vld;
  logic [RD_LAT-1:0]     r_tag_last;
  logic [CNT_W-1:0]      r_inflight;

  logic                  w_trigger;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_fifo_count;
  logic [RAMWIDTH:0]     w_fifo_head;
  logic [RAMWIDTH:0]     w_wr_data;
  logic [RAMWIDTH-1:0]   w_masked;
  logic [RAMWIDTH-1:0]   w_swapped;
  logic [OCC_W-1:0]      w_occupancy;
  logic                  w_has_space;

  // pv_q resets high so a level already asserted out of reset is not an edge.
  assign w_trigger = pm_valid && !r_pv_q;
  assign w_pop     = !w_fifo_empty && m_ready;

  // Words stored plus reads in flight, crediting a head leaving this cycle.
  assign w_occupancy = OCC_W'(r_inflight) + OCC_W'(w_fifo_count) - OCC_W'(w_pop);
  assign w_has_space = (w_occupancy < OCC_W'(FIFO_DEPTH));

  // Next-state logic and read issue.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trigger) begin
          w_state_nxt = ST_READ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        if (w_has_space) begin
          w_issue = 1'b1;
          if (r_rd_idx == LAST_IDX) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_READ;
          end
        end else begin
          w_state_nxt = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (w_pop && (r_out_idx == LAST_IDX)) begin
          w_state_nxt = ST_FINISH;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, edge detector and read/output word counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pv_q    <= 1'b1;
      r_rd_idx  <= {ADDR_WIDTH{1'b0}};
      r_out_idx <= {ADDR_WIDTH{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_pv_q  <= pm_valid;
      if ((r_state == ST_IDLE) && w_trigger) begin
        r_rd_idx  <= {ADDR_WIDTH{1'b0}};
        r_out_idx <= {ADDR_WIDTH{1'b0}};
      end else begin
        // The address parks on the final word so addr_result holds once reads stop.
        if (w_issue && (r_rd_idx != LAST_IDX)) begin
          r_rd_idx <= r_rd_idx + ADDR_WIDTH'(1);
        end
        if (w_pop) begin
          r_out_idx <= r_out_idx + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Valid/last tags travel alongside each read until its data returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld  <= {RD_LAT{1'b0}};
      r_tag_last <= {RD_LAT{1'b0}};
      r_inflight <= {CNT_W{1'b0}};
    end else begin
      r_tag_vld[0]  <= w_issue;
      r_tag_last[0] <= w_issue && (r_rd_idx == LAST_IDX);
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i]  <= r_tag_vld[i-1];
        r_tag_last[i] <= r_tag_last[i-1];
      end
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_push);
    end
  end

  assign w_push   = r_tag_vld[RD_LAT-1];
  assign w_masked = r_tag_last[RD_LAT-1] ? (dout & LAST_MASK) : dout;

  for (genvar k = 0; k < NBYTES; k++) begin : g_swap
    assign w_swapped[8*k +: 8] = w_masked[8*byte_swap(k, NBYTES) +: 8];
  end

  assign w_wr_data = {r_tag_last[RD_LAT-1], w_swapped};

  stream_fifo #(
    .WIDTH (RAMWIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_push),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_head),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  assign rd_dout     = w_issue;
  assign addr_result = r_rd_idx;
  assign m_valid     = !w_fifo_empty;
  assign m_data      = w_fifo_head[RAMWIDTH-1:0];
  assign m_last      = w_fifo_head[RAMWIDTH];
  assign busy        = (r_state == ST_READ) || (r_state == ST_DRAIN);
  assign done        = (r_state == ST_FINISH);

`ifndef SYNTHESIS
  poly_result_streamer_chk #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_count    (w_fifo_count),
    .i_inflight (r_inflight)
  );
`endif

endmodule

// File: tb/tb_poly_result_streamer.sv
// Scoreboard bench for poly_result_streamer: instance 0 has RD_LAT=1,
// instance 1 has RD_LAT=2; both read the same behavioural result memory.
module tb_poly_result_streamer;

  localparam int W     = 32;
  localparam int AW    = 11;
  localparam int WORDS = 553;
  localparam int ZW    = AW + W + 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    pm_valid;
  logic [1:0]    m_ready;
  logic [1:0]    rd_dout;
  logic [1:0]    m_valid;
  logic [1:0]    m_last;
  logic [1:0]    busy;
  logic [1:0]    done;
  logic [AW-1:0] addr_result [2];
  logic [W-1:0]  dout        [2];
  logic [W-1:0]  m_data      [2];

  logic [W-1:0]  mem [2**AW];
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q1;
  logic [W-1:0]  b_q2;

  logic [W:0]    exp_q [$];
  logic [W-1:0]  got   [WORDS];
  int            checks = 0;
  int            passes = 0;

  poly_result_streamer #(.N(17669), .RAMWIDTH(W), .ADDR_WIDTH(AW), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .pm_valid(pm_valid[0]), .addr_result(addr_result[0]),
    .rd_dout(rd_dout[0]), .dout(dout[0]), .m_data(m_data[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready[0]), .m_last(m_last[0]), .busy(busy[0]), .done(done[0]));

  poly_result_streamer #(.N(17669), .RAMWIDTH(W), .ADDR_WIDTH(AW), .RD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .pm_valid(pm_valid[1]), .addr_result(addr_result[1]),
    .rd_dout(rd_dout[1]), .dout(dout[1]), .m_data(m_data[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready[1]), .m_last(m_last[1]), .busy(busy[1]), .done(done[1]));

  // Result memory read ports: one-cycle and two-cycle latency.
  always @(posedge clk) begin
    a_q  <= mem[addr_result[0]];
    b_q1 <= mem[addr_result[1]];
    b_q2 <= b_q1;
  end
  assign dout[0] = a_q;
  assign dout[1] = b_q2;

  function automatic logic [W-1:0] model(input logic [W-1:0] x, input int idx);
    logic [W-1:0] m;
    logic [W-1:0] r;
    m = (idx == WORDS - 1) ? (x & 32'h0000_001F) : x;
    r = {<<8{m}};
    return r;
  endfunction

  function automatic logic [ZW-1:0] outs(input int s);
    return {addr_result[s], rd_dout[s], m_data[s], m_valid[s], m_last[s], busy[s], done[s]};
  endfunction

  task automatic stream(input int s, input int ready_pct, input int exp_first,
                        input int exp_done, input bit toggle, input int abort_at);
    int n, hs, issued, max_out, addr_err, first_n, done_n, next_addr, stall_err, lim;
    logic prev_stall;
    logic [W-1:0] prev_data;
    logic [W:0] e;
    n = -1; hs = 0; issued = 0; max_out = 0; addr_err = 0; first_n = -1; done_n = -1;
    next_addr = 0; stall_err = 0; prev_stall = 1'b0; prev_data = '0;
    lim = (s == 0) ? 2 : 3;
    exp_q.delete();
    for (int i = 0; i < WORDS; i++) begin
      exp_q.push_back({(i == WORDS - 1), model(mem[i], i)});
    end
    @(negedge clk); pm_valid[s] = 1'b0; m_ready[s] = 1'b0;
    @(negedge clk); @(negedge clk);
    pm_valid[s] = 1'b1;
    while (n < 20 * WORDS) begin
      @(negedge clk); n++;
      if (toggle && n == 100) pm_valid[s] = 1'b0;
      if (toggle && n == 104) pm_valid[s] = 1'b1;
      if (n == 0) begin
        checks++;
        if (busy[s] !== 1'b1) $display("FAIL busy_set: got %b want 1", busy[s]);
        else passes++;
      end
      if (prev_stall && (m_valid[s] !== 1'b1 || m_data[s] !== prev_data)) stall_err++;
      if (done[s] === 1'b1) begin
        done_n = n;
        break;
      end
      if (m_valid[s] === 1'b1 && first_n < 0) first_n = n;
      m_ready[s] = (int'($urandom_range(0, 99)) < ready_pct);
      #1;
      if (rd_dout[s] === 1'b1) begin
        if (addr_result[s] !== AW'(next_addr)) addr_err++;
        next_addr++;
        issued++;
      end
      if (m_valid[s] === 1'b1 && m_ready[s] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_word: got %h want none", m_data[s]);
        end else begin
          e = exp_q.pop_front();
          if ({m_last[s], m_data[s]} !== e)
            $display("FAIL word%0d: got last=%b data=%h want last=%b data=%h",
                     hs, m_last[s], m_data[s], e[W], e[W-1:0]);
          else passes++;
        end
        if (hs < WORDS) got[hs] = m_data[s];
        hs++;
      end
      if (issued - hs > max_out) max_out = issued - hs;
      prev_stall = (m_valid[s] === 1'b1) && !m_ready[s];
      prev_data  = m_data[s];
      if (abort_at >= 0 && hs == abort_at) return;
    end
    checks++;
    if (done_n < 0) $display("FAIL done_timeout: got no done within %0d cycles", n);
    else passes++;
    checks++;
    if (hs != WORDS || exp_q.size() != 0 || issued != WORDS)
      $display("FAIL word_count: got hs=%0d reads=%0d left=%0d want %0d", hs, issued, exp_q.size(), WORDS);
    else passes++;
    checks++;
    if (addr_err != 0) $display("FAIL read_addr: got %0d bad addresses want 0", addr_err);
    else passes++;
    checks++;
    if (max_out > lim) $display("FAIL occupancy: got %0d want <= %0d", max_out, lim);
    else passes++;
    checks++;
    if (stall_err != 0) $display("FAIL stall_hold: got %0d changes want 0", stall_err);
    else passes++;
    if (exp_first >= 0) begin
      checks++;
      if (first_n != exp_first) $display("FAIL first_valid: got %0d want %0d", first_n, exp_first);
      else passes++;
    end
    if (exp_done >= 0) begin
      checks++;
      if (done_n != exp_done) $display("FAIL done_time: got %0d want %0d", done_n, exp_done);
      else passes++;
    end
    checks++;
    if (busy[s] !== 1'b0) $display("FAIL busy_at_done: got %b want 0", busy[s]);
    else passes++;
    e = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (m_valid[s] !== 1'b0 || done[s] !== 1'b0 || busy[s] !== 1'b0) e[0] = 1'b1;
    end
    checks++;
    if (e[0]) $display("FAIL post_done_idle: got activity want idle");
    else passes++;
  endtask

  task automatic test_reset();
    logic bad;
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (outs(s) !== {ZW{1'b0}}) $display("FAIL reset_outs%0d: got %h want 0", s, outs(s));
      else passes++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy[0] !== 1'b0 || m_valid[0] !== 1'b0 || rd_dout[0] !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL level_no_trigger: got activity want idle");
    else passes++;
  endtask

  task automatic test_nominal();
    for (int i = 0; i < WORDS; i++) mem[i] = W'(i);
    stream(0, 100, 2, 555, 1'b0, -1);
    checks++;
    if (got[258] !== 32'h0201_0000) $display("FAIL swap258: got %h want 02010000", got[258]);
    else passes++;
    checks++;
    if (got[552] !== 32'h0800_0000) $display("FAIL mask552: got %h want 08000000", got[552]);
    else passes++;
  endtask

  task automatic test_mask_byteorder();
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[0]   = 32'h1122_3344;
    mem[551] = 32'hFFFF_FFFF;
    mem[552] = 32'hFFFF_FFFF;
    stream(0, 100, 2, 555, 1'b0, -1);
    checks++;
    if (got[0] !== 32'h4433_2211) $display("FAIL byte_order: got %h want 44332211", got[0]);
    else passes++;
    checks++;
    if (got[551] !== 32'hFFFF_FFFF) $display("FAIL no_mask551: got %h want ffffffff", got[551]);
    else passes++;
    checks++;
    if (got[552] !== 32'h1F00_0000) $display("FAIL mask_last: got %h want 1f000000", got[552]);
    else passes++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < WORDS; i++) mem[i] = W'(i);
    stream(1, 30, 3, -1, 1'b0, -1);
  endtask

  task automatic test_retrigger();
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    stream(0, 100, 2, 555, 1'b1, -1);
    stream(0, 100, 2, 555, 1'b0, -1);
  endtask

  task automatic test_reset_midstream();
    logic bad;
    for (int i = 0; i < WORDS; i++) mem[i] = W'(i) ^ 32'hA5A5_0000;
    stream(0, 100, -1, -1, 1'b0, 200);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (outs(0) !== {ZW{1'b0}}) $display("FAIL midreset_outs: got %h want 0", outs(0));
    else passes++;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done[0] !== 1'b0 || m_valid[0] !== 1'b0 || busy[0] !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL midreset_quiet: got activity want idle");
    else passes++;
    stream(0, 100, 2, 555, 1'b0, -1);
  endtask

  initial begin
    rst      = 1'b1;
    pm_valid = 2'b01;
    m_ready  = 2'b00;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    test_reset();
    test_nominal();
    test_mask_byteorder();
    test_backpressure();
    test_retrigger();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
